// File: rtl/uart_tx_param.sv
// Parameterised UART transmitter with a small TX FIFO.
// Frame: start, DATA_W data bits LSB first, optional parity, one or two stop bits.
module uart_tx_param #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DIV_W-1:0]              cfg_div,
  input  logic                          cfg_tx_en,
  input  logic [1:0]                    cfg_pari_mode,
  input  logic                          cfg_stop2,
  input  logic [DATA_W-1:0]             s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  output logic                          rs232_tx,
  output logic                          tx_busy,
  output logic                          int_tx_finish,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int LW  = AW + 1;
  localparam int BCW = $clog2(DATA_W);

  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];

  state_t            state_q, state_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [BCW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [DIV_W-1:0]  baud_cnt_q, baud_cnt_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [1:0]        pari_q, pari_d;
  logic              stop2_q, stop2_d;
  logic              par_q, par_d;
  logic              stop_cnt_q, stop_cnt_d;
  logic              tx_q, tx_d;

  logic              push, pop, bit_end, frame_end, start_frame, has_par;
  logic [DATA_W-1:0] head_word;

  assign head_word   = mem[rd_ptr_q];
  assign has_par     = pari_q[0] ^ pari_q[1];
  assign bit_end     = (baud_cnt_q == div_q);
  assign frame_end   = (state_q == ST_STOP) && bit_end && (stop_cnt_q || !stop2_q);
  // A new frame may start from IDLE or directly on the last stop-bit cycle (no gap).
  assign start_frame = ((state_q == ST_IDLE) || frame_end) && cfg_tx_en && (level_q != '0);
  assign push        = s_valid && s_ready;
  assign pop         = start_frame;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= s_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      baud_cnt_q <= '0;
      div_q      <= '0;
      pari_q     <= '0;
      stop2_q    <= 1'b0;
      par_q      <= 1'b0;
      stop_cnt_q <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      baud_cnt_q <= baud_cnt_d;
      div_q      <= div_d;
      pari_q     <= pari_d;
      stop2_q    <= stop2_d;
      par_q      <= par_d;
      stop_cnt_q <= stop_cnt_d;
      tx_q       <= tx_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    baud_cnt_d = baud_cnt_q;
    div_d      = div_q;
    pari_d     = pari_q;
    stop2_d    = stop2_q;
    par_d      = par_q;
    stop_cnt_d = stop_cnt_q;
    tx_d       = tx_q;

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    if (state_q != ST_IDLE) baud_cnt_d = bit_end ? '0 : baud_cnt_q + DIV_W'(1);

    if (bit_end) begin
      case (state_q)
        ST_START: begin
          state_d   = ST_DATA;
          tx_d      = shreg_q[0];
          shreg_d   = shreg_q >> 1;
          bit_cnt_d = '0;
        end
        ST_DATA: begin
          if (bit_cnt_q == BCW'(DATA_W - 1)) begin
            state_d    = has_par ? ST_PARITY : ST_STOP;
            tx_d       = has_par ? par_q : 1'b1;
            stop_cnt_d = 1'b0;
          end else begin
            bit_cnt_d = bit_cnt_q + BCW'(1);
            tx_d      = shreg_q[0];
            shreg_d   = shreg_q >> 1;
          end
        end
        ST_PARITY: begin
          state_d    = ST_STOP;
          tx_d       = 1'b1;
          stop_cnt_d = 1'b0;
        end
        ST_STOP: begin
          if (frame_end) begin
            state_d = ST_IDLE;
            tx_d    = 1'b1;
          end else begin
            stop_cnt_d = 1'b1;
          end
        end
        default: ;
      endcase
    end

    // Frame configuration is captured only here, so mid-frame changes wait for the next frame.
    if (start_frame) begin
      state_d    = ST_START;
      tx_d       = 1'b0;
      baud_cnt_d = '0;
      div_d      = cfg_div;
      pari_d     = cfg_pari_mode;
      stop2_d    = cfg_stop2;
      shreg_d    = head_word;
      par_d      = (cfg_pari_mode == 2'b01) ? ~^head_word : ^head_word;
    end
  end

  always_comb begin
    s_ready       = (level_q != LW'(FIFO_DEPTH));
    tx_busy       = (state_q != ST_IDLE);
    int_tx_finish = frame_end;
  end

  assign rs232_tx   = tx_q;
  assign fifo_level = level_q;

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed self-checking bench for uart_tx_param (DATA_W=8, FIFO_DEPTH=4).
module tb_uart_tx_param;
  localparam int DATA_W     = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int DIV_W      = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic [DIV_W-1:0]  cfg_div = 16'd3;
  logic              cfg_tx_en = 1'b0;
  logic [1:0]        cfg_pari_mode = 2'b00;
  logic              cfg_stop2 = 1'b0;
  logic [DATA_W-1:0] s_data = '0;
  logic              s_valid = 1'b0;
  logic              s_ready, rs232_tx, tx_busy, int_tx_finish;
  logic [2:0]        fifo_level;

  int n_checks = 0;
  int n_fail   = 0;

  logic exp_line_q[$], exp_fin_q[$];
  logic obs_line_q[$], obs_fin_q[$], obs_busy_q[$];

  uart_tx_param #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .DIV_W(DIV_W)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_div(cfg_div), .cfg_tx_en(cfg_tx_en),
    .cfg_pari_mode(cfg_pari_mode), .cfg_stop2(cfg_stop2), .s_data(s_data),
    .s_valid(s_valid), .s_ready(s_ready), .rs232_tx(rs232_tx), .tx_busy(tx_busy),
    .int_tx_finish(int_tx_finish), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    exp_line_q.delete(); exp_fin_q.delete();
    obs_line_q.delete(); obs_fin_q.delete(); obs_busy_q.delete();
  endtask

  // bits[0] is the first bit on the line; finish is expected on the frame's last cycle.
  task automatic add_frame(input logic [15:0] bits, input int nbits, input int bitlen);
    for (int b = 0; b < nbits; b++)
      for (int c = 0; c < bitlen; c++) begin
        exp_line_q.push_back(bits[b]);
        exp_fin_q.push_back((b == nbits - 1) && (c == bitlen - 1));
      end
  endtask

  task automatic capture(input int n);
    for (int i = 0; i < n; i++) begin
      obs_line_q.push_back(rs232_tx);
      obs_fin_q.push_back(int_tx_finish);
      obs_busy_q.push_back(tx_busy);
      tick();
    end
  endtask

  function automatic int first_line_diff();
    for (int i = 0; i < exp_line_q.size(); i++)
      if (i >= obs_line_q.size() || obs_line_q[i] !== exp_line_q[i]) return i;
    return -1;
  endfunction

  function automatic int first_fin_diff();
    for (int i = 0; i < exp_fin_q.size(); i++)
      if (i >= obs_fin_q.size() || obs_fin_q[i] !== exp_fin_q[i]) return i;
    return -1;
  endfunction

  function automatic int count_busy_low();
    int n = 0;
    foreach (obs_busy_q[i]) if (obs_busy_q[i] !== 1'b1) n++;
    return n;
  endfunction

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #12;
    n_checks++; if (rs232_tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b need 1", rs232_tx); end
    n_checks++; if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b need 0", tx_busy); end
    n_checks++; if (int_tx_finish !== 1'b0) begin n_fail++; $display("FAIL reset_finish: got %b need 0", int_tx_finish); end
    n_checks++; if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL reset_level: got %0d need 0", fifo_level); end
    n_checks++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b need 1", s_ready); end
    tick();
    rst_n = 1'b1;
    cfg_tx_en = 1'b1;
    clear_logs();
    capture(10);
    n_checks++; if (obs_busy_q.sum() with (int'(item)) != 0 || rs232_tx !== 1'b1) begin
      n_fail++; $display("FAIL reset_no_frame: busy cycles %0d tx %b need 0 and 1", obs_busy_q.sum() with (int'(item)), rs232_tx);
    end
    $display("test_reset done");
  endtask

  task automatic test_basic_frame();
    int d;
    cfg_div = 16'd3; cfg_pari_mode = 2'b00; cfg_stop2 = 1'b0; cfg_tx_en = 1'b1;
    clear_logs();
    s_data = 8'hA5; s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    n_checks++; if (fifo_level !== 3'd1 || rs232_tx !== 1'b1) begin
      n_fail++; $display("FAIL basic_accept: level %0d tx %b need 1 and 1", fifo_level, rs232_tx);
    end
    tick();
    add_frame(16'b11_0100_1010, 10, 4);
    capture(40);
    d = first_line_diff();
    n_checks++; if (d !== -1) begin n_fail++; $display("FAIL basic_line: cycle %0d got %b need %b", d, obs_line_q[d], exp_line_q[d]); end
    d = first_fin_diff();
    n_checks++; if (d !== -1) begin n_fail++; $display("FAIL basic_finish: cycle %0d got %b need %b", d, obs_fin_q[d], exp_fin_q[d]); end
    n_checks++; if (count_busy_low() !== 0) begin n_fail++; $display("FAIL basic_busy: %0d idle cycles in frame need 0", count_busy_low()); end
    n_checks++; if (rs232_tx !== 1'b1 || tx_busy !== 1'b0 || fifo_level !== 3'd0) begin
      n_fail++; $display("FAIL basic_after: tx %b busy %b level %0d need 1 0 0", rs232_tx, tx_busy, fifo_level);
    end
    $display("test_basic_frame done (0xA5, div 3, no parity)");
  endtask

  task automatic test_parity();
    int d;
    // Odd parity with two stop bits: 12 bits x 4 = 48 cycles, parity bit 1.
    cfg_div = 16'd3; cfg_pari_mode = 2'b01; cfg_stop2 = 1'b1;
    clear_logs();
    s_data = 8'hA5; s_valid = 1'b1; tick(); s_valid = 1'b0; tick();
    add_frame(16'b1111_0100_1010, 12, 4);
    capture(48);
    d = first_line_diff();
    n_checks++; if (d !== -1) begin n_fail++; $display("FAIL odd_line: cycle %0d got %b need %b", d, obs_line_q[d], exp_line_q[d]); end
    d = first_fin_diff();
    n_checks++; if (d !== -1) begin n_fail++; $display("FAIL odd_finish: cycle %0d got %b need %b", d, obs_fin_q[d], exp_fin_q[d]); end
    $display("test_parity odd/stop2 done");
    // Even parity with one stop bit: 11 bits x 4 = 44 cycles, parity bit 0.
    cfg_pari_mode = 2'b10; cfg_stop2 = 1'b0;
    clear_logs();
    s_data = 8'hA5; s_valid = 1'b1; tick(); s_valid = 1'b0; tick();
    add_frame(16'b101_0100_1010, 11, 4);
    capture(44);
    d = first_line_diff();
    n_checks++; if (d !== -1) begin n_fail++; $display("FAIL even_line: cycle %0d got %b need %b", d, obs_line_q[d], exp_line_q[d]); end
    d = first_fin_diff();
    n_checks++; if (d !== -1) begin n_fail++; $display("FAIL even_finish: cycle %0d got %b need %b", d, obs_fin_q[d], exp_fin_q[d]); end
    n_checks++; if (rs232_tx !== 1'b1 || tx_busy !== 1'b0) begin
      n_fail++; $display("FAIL even_after: tx %b busy %b need 1 0", rs232_tx, tx_busy);
    end
    $display("test_parity even/stop1 done");
  endtask

  task automatic test_fifo_back_to_back();
    logic [7:0] words [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    int d, pulses;
    cfg_div = 16'd1; cfg_pari_mode = 2'b00; cfg_stop2 = 1'b0; cfg_tx_en = 1'b0;
    clear_logs();
    for (int i = 0; i < 4; i++) begin
      s_data = words[i]; s_valid = 1'b1; tick();
    end
    n_checks++; if (fifo_level !== 3'd4 || s_ready !== 1'b0) begin
      n_fail++; $display("FAIL fifo_full: level %0d ready %b need 4 0", fifo_level, s_ready);
    end
    s_data = words[4]; tick(); s_valid = 1'b0;
    n_checks++; if (fifo_level !== 3'd4) begin n_fail++; $display("FAIL fifo_drop: level %0d need 4", fifo_level); end
    capture(5);
    n_checks++; if (count_busy_low() !== 5 || rs232_tx !== 1'b1) begin
      n_fail++; $display("FAIL fifo_disabled: idle cycles %0d tx %b need 5 1", count_busy_low(), rs232_tx);
    end
    clear_logs();
    cfg_tx_en = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) add_frame({6'b0, 1'b1, words[i], 1'b0}, 10, 2);
    capture(80);
    d = first_line_diff();
    n_checks++; if (d !== -1) begin n_fail++; $display("FAIL b2b_line: cycle %0d got %b need %b", d, obs_line_q[d], exp_line_q[d]); end
    d = first_fin_diff();
    n_checks++; if (d !== -1) begin n_fail++; $display("FAIL b2b_finish: cycle %0d got %b need %b", d, obs_fin_q[d], exp_fin_q[d]); end
    pulses = obs_fin_q.sum() with (int'(item));
    n_checks++; if (pulses !== 4) begin n_fail++; $display("FAIL b2b_pulses: got %0d need 4", pulses); end
    n_checks++; if (count_busy_low() !== 0) begin n_fail++; $display("FAIL b2b_gap: %0d idle cycles need 0", count_busy_low()); end
    n_checks++; if (rs232_tx !== 1'b1 || tx_busy !== 1'b0 || fifo_level !== 3'd0) begin
      n_fail++; $display("FAIL b2b_after: tx %b busy %b level %0d need 1 0 0", rs232_tx, tx_busy, fifo_level);
    end
    $display("test_fifo_back_to_back done (4 frames, fifth word dropped)");
  endtask

  task automatic test_cfg_change();
    int d;
    cfg_div = 16'd3; cfg_pari_mode = 2'b00; cfg_stop2 = 1'b0; cfg_tx_en = 1'b1;
    clear_logs();
    s_data = 8'h3C; s_valid = 1'b1; tick();
    s_data = 8'hC3; tick(); s_valid = 1'b0;
    add_frame({6'b0, 1'b1, 8'h3C, 1'b0}, 10, 4);
    add_frame({6'b0, 1'b1, 8'hC3, 1'b0}, 10, 8);
    capture(20);
    cfg_div = 16'd7;
    capture(100);
    d = first_line_diff();
    n_checks++; if (d !== -1) begin n_fail++; $display("FAIL cfgchg_line: cycle %0d got %b need %b", d, obs_line_q[d], exp_line_q[d]); end
    d = first_fin_diff();
    n_checks++; if (d !== -1) begin n_fail++; $display("FAIL cfgchg_finish: cycle %0d got %b need %b", d, obs_fin_q[d], exp_fin_q[d]); end
    n_checks++; if (rs232_tx !== 1'b1 || tx_busy !== 1'b0) begin
      n_fail++; $display("FAIL cfgchg_after: tx %b busy %b need 1 0", rs232_tx, tx_busy);
    end
    $display("test_cfg_change done (div 3 -> 7 mid-frame)");
  endtask

  task automatic test_reset_mid_frame();
    int bad;
    cfg_div = 16'd3; cfg_pari_mode = 2'b00; cfg_stop2 = 1'b0; cfg_tx_en = 1'b1;
    s_data = 8'h5A; s_valid = 1'b1; tick();
    s_data = 8'h0F; tick();
    s_data = 8'hF0; tick(); s_valid = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    n_checks++; if (tx_busy !== 1'b1 || fifo_level !== 3'd2) begin
      n_fail++; $display("FAIL rstmid_pre: busy %b level %0d need 1 2", tx_busy, fifo_level);
    end
    rst_n = 1'b0;
    #1;
    n_checks++; if (rs232_tx !== 1'b1 || fifo_level !== 3'd0) begin
      n_fail++; $display("FAIL rstmid_abort: tx %b level %0d need 1 0", rs232_tx, fifo_level);
    end
    n_checks++; if (tx_busy !== 1'b0 || s_ready !== 1'b1 || int_tx_finish !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_outputs: busy %b ready %b finish %b need 0 1 0", tx_busy, s_ready, int_tx_finish);
    end
    tick();
    rst_n = 1'b1;
    clear_logs();
    capture(40);
    bad = 0;
    foreach (obs_line_q[i]) if (obs_line_q[i] !== 1'b1 || obs_busy_q[i] !== 1'b0) bad++;
    n_checks++; if (bad !== 0 || fifo_level !== 3'd0) begin
      n_fail++; $display("FAIL rstmid_idle: %0d non-idle cycles, level %0d need 0 0", bad, fifo_level);
    end
    $display("test_reset_mid_frame done");
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_parity();
    test_fifo_back_to_back();
    test_cfg_change();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
